// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   fwd_sel_t       : EX operand forwarding select encoding
//   hz_state_t      : hazard controller FSM states
//   RESULT_SRC_LOAD : ResultSrcE encoding that marks a load in E
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        ST_INIT     = 2'b00,
        ST_RUN      = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_ERROR    = 2'b11
    } hz_state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage : hazard_pkg

// File: rtl/hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// hazard_fwd_sel
// One-operand forwarding compare. The M stage wins over the W stage because
// it holds the younger result; register x0 never forwards.
// Ports:
//   rs          in  5  source register of the E instruction
//   rd_m        in  5  destination register in M
//   reg_write_m in  1  M instruction writes the register file
//   rd_w        in  5  destination register in W
//   reg_write_w in  1  W instruction writes the register file
//   sel         out 2  forwarding select (fwd_sel_t)
// -----------------------------------------------------------------------------
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output fwd_sel_t   sel
);

    logic hit_m_s;
    logic hit_w_s;

    assign hit_m_s = reg_write_m && (rd_m != 5'd0) && (rd_m == rs);
    assign hit_w_s = reg_write_w && (rd_w != 5'd0) && (rd_w == rs);

    // Priority select: M result first, then W result, else register file
    always_comb begin
        sel = FWD_NONE;
        if (hit_m_s) begin
            sel = FWD_MEM;
        end else if (hit_w_s) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_NONE;
        end
    end

endmodule : hazard_fwd_sel

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: EX operand forwarding selects, load-use stall,
// branch/jump flush, data-memory wait stall with timeout and a post-reset
// bubble. Stall/flush outputs are combinational from FSM state and inputs so
// that they act in the same cycle as the hazard they cover.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance
// counters; when undefined the counter ports are tied to zero).
// Ports:
//   clk, rst_n                    clock (rising edge), async active-low reset
//   Rs1D, Rs2D                    source registers in D
//   Rs1E, Rs2E, RdE               source/destination registers in E
//   RegWriteE, ResultSrcE         E writes regfile / E result select (01=load)
//   RdM, RdW, RegWriteM, RegWriteW  M/W destination registers and write enables
//   PCSrcE                        branch taken or jump resolved in E
//   MemReqM, MemReadyM            data memory request / completion in M
//   ForwardAE, ForwardBE          operand A/B forwarding selects
//   StallF/D/E/M, FlushD/E/W      pipeline register hold / bubble controls
//   mem_err                       sticky memory timeout flag
//   perf_stall_cnt, perf_flush_cnt  performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           Rs1E,
    input  logic [4:0]           Rs2E,
    input  logic [4:0]           RdE,
    input  logic                 RegWriteE,
    input  logic [1:0]           ResultSrcE,
    input  logic [4:0]           RdM,
    input  logic [4:0]           RdW,
    input  logic                 RegWriteM,
    input  logic                 RegWriteW,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 mem_err,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    hz_state_t          state_r;
    hz_state_t          state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_nxt_s;

    logic     memwait_s;
    logic     load_use_s;
    fwd_sel_t fwd_a_s;
    fwd_sel_t fwd_b_s;

    logic stall_f_s, stall_d_s, stall_e_s, stall_m_s;
    logic flush_d_s, flush_e_s, flush_w_s;

    // ------------------------------------------------------------------
    // Forwarding: independent of the FSM
    // ------------------------------------------------------------------
    hazard_fwd_sel u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .sel         (fwd_b_s)
    );

    assign ForwardAE = fwd_a_s;
    assign ForwardBE = fwd_b_s;

    // Memory wait only counts once the pipeline is running (not in INIT/ERROR)
    assign memwait_s = MemReqM && !MemReadyM &&
                       ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT));

    assign load_use_s = (ResultSrcE == RESULT_SRC_LOAD) && RegWriteE &&
                        (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // Next-state and wait counter update
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_INIT: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
            ST_RUN: begin
                if (memwait_s) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (MemReadyM) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end else if (wait_cnt_r == WAIT_W'(TIMEOUT_CYCLES)) begin
                    state_nxt_s    = ST_ERROR;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ERROR: begin
                state_nxt_s = ST_ERROR;
            end
            default: begin
                state_nxt_s    = ST_ERROR;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
            end
        endcase
    end

    // Stall/flush outputs by priority: INIT bubble, memory wait/error, branch, load-use
    always_comb begin
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        stall_m_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        flush_w_s = 1'b0;
        if (state_r == ST_INIT) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (memwait_s || (state_r == ST_ERROR)) begin
            // Freeze F..M and drop the W slot so a stalled M result is not written twice
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            stall_e_s = 1'b1;
            stall_m_s = 1'b1;
            flush_w_s = 1'b1;
        end else if (PCSrcE) begin
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else if (load_use_s) begin
            stall_f_s = 1'b1;
            stall_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            stall_f_s = 1'b0;
            flush_e_s = 1'b0;
        end
    end

    assign StallF  = stall_f_s;
    assign StallD  = stall_d_s;
    assign StallE  = stall_e_s;
    assign StallM  = stall_m_s;
    assign FlushD  = flush_d_s;
    assign FlushE  = flush_e_s;
    assign FlushW  = flush_w_s;
    assign mem_err = (state_r == ST_ERROR);

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_r;
    logic [CNT_WIDTH-1:0] flush_cnt_r;

    // Free-running wrap-around counters of StallF cycles and non-INIT FlushE cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_WIDTH{1'b0}};
            flush_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (stall_f_s) begin
                stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_e_s && (state_r != ST_INIT)) begin
                flush_cnt_r <= flush_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_r;
    assign perf_flush_cnt = flush_cnt_r;
`else
    assign perf_stall_cnt = {CNT_WIDTH{1'b0}};
    assign perf_flush_cnt = {CNT_WIDTH{1'b0}};
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled
// combinationally a further time unit later, well away from the edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        mem_err;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int n_checks;
    int n_passed;

    hazard_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_WIDTH      (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Rs1D           (Rs1D),
        .Rs2D           (Rs2D),
        .Rs1E           (Rs1E),
        .Rs2E           (Rs2E),
        .RdE            (RdE),
        .RegWriteE      (RegWriteE),
        .ResultSrcE     (ResultSrcE),
        .RdM            (RdM),
        .RdW            (RdW),
        .RegWriteM      (RegWriteM),
        .RegWriteW      (RegWriteW),
        .PCSrcE         (PCSrcE),
        .MemReqM        (MemReqM),
        .MemReadyM      (MemReadyM),
        .ForwardAE      (ForwardAE),
        .ForwardBE      (ForwardBE),
        .StallF         (StallF),
        .StallD         (StallD),
        .StallE         (StallE),
        .StallM         (StallM),
        .FlushD         (FlushD),
        .FlushE         (FlushE),
        .FlushW         (FlushW),
        .mem_err        (mem_err),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pack stall/flush outputs as {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    function automatic logic [31:0] ctl();
        return {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();

        // Reset / INIT bubble
        check_eq("init_ctl", ctl(), 32'b0000111);
        check_eq("init_mem_err", {31'd0, mem_err}, 32'd0);
        check_eq("init_perf_stall", perf_stall_cnt, 32'd0);
        check_eq("init_perf_flush", perf_flush_cnt, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("init_after_release", ctl(), 32'b0000111);
        step();
        check_eq("run_idle_ctl", ctl(), 32'b0000000);

        // Forwarding priority: M over W
        RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1; Rs1E = 5'd5;
        #1;
        check_eq("fwdA_mem", {30'd0, ForwardAE}, 32'd2);
        RegWriteM = 1'b0;
        #1;
        check_eq("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
        // x0 never forwards
        RdM = 5'd0; RegWriteM = 1'b1; RdW = 5'd0; Rs2E = 5'd0;
        #1;
        check_eq("fwdB_x0", {30'd0, ForwardBE}, 32'd0);
        // B from W while M writes a different register
        RdM = 5'd3; RdW = 5'd9; Rs2E = 5'd9;
        #1;
        check_eq("fwdB_wb", {30'd0, ForwardBE}, 32'd1);
        check_eq("fwdA_none", {30'd0, ForwardAE}, 32'd0);
        idle_inputs();

        // Load-use: one stall cycle, then the bubble reaches E
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        check_eq("load_use_ctl", ctl(), 32'b1100010);
        step();
        ResultSrcE = 2'b00; RegWriteE = 1'b0; RdE = 5'd0;
        #1;
        check_eq("load_use_released", ctl(), 32'b0000000);
        // Load writing x0 is not a hazard
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        check_eq("load_use_x0", ctl(), 32'b0000000);

        // Branch wins over load-use
        RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
        #1;
        check_eq("branch_over_lu", ctl(), 32'b0000110);
        idle_inputs();
        step();

        // Memory wait: 3 stalled cycles with a branch pending, then ready
        MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("memwait_ctl_%0d", i), ctl(), 32'b1111001);
            step();
        end
        MemReadyM = 1'b1;
        #1;
        check_eq("memwait_ready_ctl", ctl(), 32'b0000110);
        PCSrcE = 1'b0;
        step();
        MemReqM = 1'b0; MemReadyM = 1'b0;
        #1;
        check_eq("memwait_back_run", ctl(), 32'b0000000);
        check_eq("memwait_no_err", {31'd0, mem_err}, 32'd0);

        // Timeout: 5 stalled cycles, then ERROR
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("timeout_stall_%0d", i), {mem_err, StallF}, {1'b0, 1'b1});
            step();
        end
        check_eq("timeout_mem_err", {31'd0, mem_err}, 32'd1);
        MemReqM = 1'b0; PCSrcE = 1'b1;
        #1;
        check_eq("error_ctl", ctl(), 32'b1111001);
        MemReadyM = 1'b1;
        step();
        check_eq("error_sticky", {31'd0, mem_err}, 32'd1);

        // Asynchronous reset mid-cycle returns to INIT and clears mem_err
        rst_n = 1'b0;
        #1;
        check_eq("rst_init_ctl", ctl(), 32'b0000111);
        check_eq("rst_mem_err", {31'd0, mem_err}, 32'd0);
        idle_inputs();
        #2;
        rst_n = 1'b1;
        step();
        check_eq("rst_run_ctl", ctl(), 32'b0000000);

`ifndef HAZARD_PERF_CNT_EN
        check_eq("perf_stall_tied", perf_stall_cnt, 32'd0);
        check_eq("perf_flush_tied", perf_flush_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
